fht_bank_wr: RTL and testbench

- Write-back side of the FHT stage datapath: takes the four butterfly-block results per cycle (Y_0..Y_3), realigns them with the bank address issued by the reader, and drives one write per cycle into the four data RAM banks.
- On the last stage, results are not written back to the banks. They are pushed into an output FIFO with a valid/ready stream interface, and the block back-pressures the bank reader through oSTALL.
- It tracks butterflies per stage and signals stage completion to the stage sequencer.

---
 rtl/fht_bank_wr_if.sv | 48 ++++
 rtl/fht_bank_wr.sv | 158 +++++++++++++++
 tb/tb_fht_bank_wr.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fht_bank_wr_if.sv
// Stage control, reader, butterfly-result, bank-write and output-stream signals of fht_bank_wr.
// The master side drives the stage/reader/butterfly inputs; the slave side is the write-back block.
interface fht_bank_wr_if #(
  parameter int D_BIT = 17,
  parameter int A_BIT = 9
);
  logic                    iSTART;
  logic                    iST_LAST;
  logic [A_BIT:0]          iN_BUT;
  logic                    iRD_VALID;
  logic [A_BIT-1:0]        iRD_ADDR;
  logic signed [D_BIT-1:0] iY_0;
  logic signed [D_BIT-1:0] iY_1;
  logic signed [D_BIT-1:0] iY_2;
  logic signed [D_BIT-1:0] iY_3;
  logic                    oSTALL;
  logic                    oWR_EN;
  logic [A_BIT-1:0]        oWR_ADDR;
  logic signed [D_BIT-1:0] oWR_D_0;
  logic signed [D_BIT-1:0] oWR_D_1;
  logic signed [D_BIT-1:0] oWR_D_2;
  logic signed [D_BIT-1:0] oWR_D_3;
  logic                    oOUT_VALID;
  logic                    iOUT_READY;
  logic signed [D_BIT-1:0] oOUT_Y_0;
  logic signed [D_BIT-1:0] oOUT_Y_1;
  logic signed [D_BIT-1:0] oOUT_Y_2;
  logic signed [D_BIT-1:0] oOUT_Y_3;
  logic                    oBUSY;
  logic                    oDONE;
  logic                    oERR;

  modport master (
    output iSTART, iST_LAST, iN_BUT, iRD_VALID, iRD_ADDR,
    output iY_0, iY_1, iY_2, iY_3, iOUT_READY,
    input  oSTALL, oWR_EN, oWR_ADDR, oWR_D_0, oWR_D_1, oWR_D_2, oWR_D_3,
    input  oOUT_VALID, oOUT_Y_0, oOUT_Y_1, oOUT_Y_2, oOUT_Y_3,
    input  oBUSY, oDONE, oERR
  );

  modport slave (
    input  iSTART, iST_LAST, iN_BUT, iRD_VALID, iRD_ADDR,
    input  iY_0, iY_1, iY_2, iY_3, iOUT_READY,
    output oSTALL, oWR_EN, oWR_ADDR, oWR_D_0, oWR_D_1, oWR_D_2, oWR_D_3,
    output oOUT_VALID, oOUT_Y_0, oOUT_Y_1, oOUT_Y_2, oOUT_Y_3,
    output oBUSY, oDONE, oERR
  );
endinterface

// File: rtl/fht_bank_wr.sv
// FHT stage write-back: realigns butterfly results with their read address, writes them to the
// four banks, or in the last stage queues them into a back-pressured output FIFO.
module fht_bank_wr #(
  parameter int D_BIT      = 17,
  parameter int A_BIT      = 9,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 8
) (
  input logic         iCLK,
  input logic         iRESET,
  fht_bank_wr_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 4;
  localparam logic [A_BIT:0] ONE = (A_BIT+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   last_q;
  logic [A_BIT:0]         n_but_q;
  logic [A_BIT:0]         rd_cnt;
  logic [LAT-1:0]         dl_valid;
  logic [A_BIT-1:0]       dl_addr [LAT];
  logic [3:0]             inflight;
  logic [4*D_BIT-1:0]     mem [FIFO_DEPTH];
  logic [4*D_BIT-1:0]     head;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          fifo_count;
  logic [SW-1:0]          occupancy;
  logic                   wr_en_q;
  logic [A_BIT-1:0]       wr_addr_q;
  logic [4*D_BIT-1:0]     wr_data_q;
  logic                   err_q;
  logic                   rd_take, out_v, push_req, fifo_full, push, pop, stall;

  assign rd_take   = (state == RUN) && bus.iRD_VALID;
  assign out_v     = dl_valid[LAT-1];
  assign push_req  = out_v && last_q;
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign push      = push_req && !fifo_full;
  assign pop       = (fifo_count != '0) && bus.iOUT_READY;
  // Reads already in the delay line will land in the FIFO, so they count against its space.
  assign occupancy = SW'(fifo_count) + SW'(inflight);
  assign stall     = last_q && (occupancy >= SW'(FIFO_DEPTH));

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.iSTART) state_nxt = (bus.iN_BUT == '0) ? DRAIN : RUN;
      RUN:   if (rd_take && ((rd_cnt + ONE) == n_but_q)) state_nxt = DRAIN;
      DRAIN: if ((inflight == '0) && (!last_q || (fifo_count == '0))) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      last_q   <= 1'b0;
      n_but_q  <= '0;
      rd_cnt   <= '0;
      err_q    <= 1'b0;
      inflight <= '0;
    end else begin
      if ((state == IDLE) && bus.iSTART) begin
        last_q  <= bus.iST_LAST;
        n_but_q <= bus.iN_BUT;
        rd_cnt  <= '0;
      end else if (rd_take) begin
        rd_cnt <= rd_cnt + ONE;
      end
      if ((rd_take && stall) || (push_req && fifo_full)) err_q <= 1'b1;
      case ({rd_take, out_v})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Never stalled: the butterfly pipeline delivers results LAT cycles after the read regardless.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      dl_valid <= '0;
      for (int i = 0; i < LAT; i++) dl_addr[i] <= '0;
    end else begin
      dl_valid[0] <= rd_take;
      dl_addr[0]  <= bus.iRD_ADDR;
      for (int i = 1; i < LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_addr[i]  <= dl_addr[i-1];
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= out_v && !last_q;
      if (out_v && !last_q) begin
        wr_addr_q <= dl_addr[LAT-1];
        wr_data_q <= {bus.iY_3, bus.iY_2, bus.iY_1, bus.iY_0};
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) mem[wr_ptr] <= {bus.iY_3, bus.iY_2, bus.iY_1, bus.iY_0};
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage is not reset, so the head is masked to keep the stream outputs at 0 while empty.
  assign head = (fifo_count != '0) ? mem[rd_ptr] : '0;

  assign bus.oSTALL     = stall;
  assign bus.oWR_EN     = wr_en_q;
  assign bus.oWR_ADDR   = wr_addr_q;
  assign bus.oWR_D_0    = wr_data_q[0*D_BIT +: D_BIT];
  assign bus.oWR_D_1    = wr_data_q[1*D_BIT +: D_BIT];
  assign bus.oWR_D_2    = wr_data_q[2*D_BIT +: D_BIT];
  assign bus.oWR_D_3    = wr_data_q[3*D_BIT +: D_BIT];
  assign bus.oOUT_VALID = (fifo_count != '0);
  assign bus.oOUT_Y_0   = head[0*D_BIT +: D_BIT];
  assign bus.oOUT_Y_1   = head[1*D_BIT +: D_BIT];
  assign bus.oOUT_Y_2   = head[2*D_BIT +: D_BIT];
  assign bus.oOUT_Y_3   = head[3*D_BIT +: D_BIT];
  assign bus.oBUSY      = (state != IDLE);
  assign bus.oDONE      = (state == DONE);
  assign bus.oERR       = err_q;
endmodule

// File: tb/tb_fht_bank_wr.sv
// Scoreboard bench for fht_bank_wr: read addresses are queued when driven and compared against
// bank writes or FIFO pops as the DUT produces them.
module tb_fht_bank_wr;
  localparam int D_BIT      = 17;
  localparam int A_BIT      = 9;
  localparam int LAT        = 3;
  localparam int FIFO_DEPTH = 8;

  logic iCLK;
  logic iRESET;
  int   checks;
  int   errors;
  bit   cur_last;
  int   ready_mode;
  logic [A_BIT-1:0] wr_q[$];
  logic [A_BIT-1:0] fifo_q[$];
  logic [A_BIT-1:0] p_addr [LAT];

  fht_bank_wr_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) bus ();

  fht_bank_wr #(.D_BIT(D_BIT), .A_BIT(A_BIT), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic logic [D_BIT-1:0] yval(input logic [A_BIT-1:0] a, input int k);
    return D_BIT'(int'(a) + 100 + 1000 * k);
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Butterfly model: results for the read seen LAT edges ago.
  initial begin
    for (int i = 0; i < LAT; i++) p_addr[i] = '0;
    bus.iY_0 = '0; bus.iY_1 = '0; bus.iY_2 = '0; bus.iY_3 = '0;
    forever begin
      @(posedge iCLK);
      for (int i = LAT - 1; i > 0; i--) p_addr[i] = p_addr[i-1];
      p_addr[0] = bus.iRD_ADDR;
      #1;
      bus.iY_0 = yval(p_addr[LAT-1], 0);
      bus.iY_1 = yval(p_addr[LAT-1], 1);
      bus.iY_2 = yval(p_addr[LAT-1], 2);
      bus.iY_3 = yval(p_addr[LAT-1], 3);
    end
  end

  initial begin
    forever begin
      case (ready_mode)
        0:       bus.iOUT_READY = 1'b0;
        1:       bus.iOUT_READY = 1'b1;
        default: bus.iOUT_READY = ~bus.iOUT_READY;
      endcase
      @(posedge iCLK);
      #1;
    end
  end

  always @(negedge iCLK) begin
    if (bus.oWR_EN === 1'b1) begin
      if (wr_q.size() == 0) checkOutput("wr_unexpected", 1, 0);
      else begin
        logic [A_BIT-1:0] a;
        a = wr_q.pop_front();
        checkOutput("wr_addr", bus.oWR_ADDR, a);
        checkOutput("wr_d0", bus.oWR_D_0, yval(a, 0));
        checkOutput("wr_d3", bus.oWR_D_3, yval(a, 3));
      end
    end
    if (bus.oOUT_VALID === 1'b1 && bus.iOUT_READY === 1'b1) begin
      if (fifo_q.size() == 0) checkOutput("out_unexpected", 1, 0);
      else begin
        logic [A_BIT-1:0] a;
        a = fifo_q.pop_front();
        checkOutput("out_y0", bus.oOUT_Y_0, yval(a, 0));
        checkOutput("out_y3", bus.oOUT_Y_3, yval(a, 3));
      end
    end
  end

  task automatic applyStimulus(input logic [A_BIT-1:0] addr, input bit expect_out);
    bus.iRD_VALID = 1'b1;
    bus.iRD_ADDR  = addr;
    if (expect_out) begin
      if (cur_last) fifo_q.push_back(addr);
      else          wr_q.push_back(addr);
    end
    tick();
    bus.iRD_VALID = 1'b0;
  endtask

  task automatic start_stage(input bit last, input int n);
    cur_last     = last;
    bus.iST_LAST = last;
    bus.iN_BUT   = (A_BIT+1)'(n);
    bus.iSTART   = 1'b1;
    tick();
    bus.iSTART   = 1'b0;
  endtask

  task automatic issue_until(input int target, input int max_cyc, input int base, inout int issued);
    for (int i = 0; i < max_cyc && issued < target; i++) begin
      if (bus.oSTALL === 1'b0) begin
        applyStimulus(A_BIT'(base + issued), 1'b1);
        issued++;
      end else begin
        tick();
      end
    end
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    bit found;
    found = 0;
    cyc = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge iCLK);
      cyc++;
      if (bus.oDONE === 1'b1) begin
        found = 1;
        break;
      end
      @(posedge iCLK);
      #1;
    end
    if (!found) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int issued;
    checks = 0; errors = 0; cur_last = 0; ready_mode = 0;
    iRESET = 1'b1;
    bus.iSTART = 0; bus.iST_LAST = 0; bus.iN_BUT = '0; bus.iRD_VALID = 0; bus.iRD_ADDR = '0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    checkOutput("rst_flags", {bus.oWR_EN, bus.oSTALL, bus.oOUT_VALID, bus.oBUSY, bus.oDONE, bus.oERR}, 0);
    checkOutput("rst_wr", {bus.oWR_ADDR, bus.oWR_D_0, bus.oWR_D_3}, 0);
    checkOutput("rst_out", {bus.oOUT_Y_0, bus.oOUT_Y_3}, 0);
    @(posedge iCLK); #1;
    iRESET = 1'b0;
    repeat (3) tick();

    $display("[TB] non-last stage, 4 reads");
    start_stage(0, 4);
    for (int a = 5; a <= 8; a++) applyStimulus(A_BIT'(a), 1'b1);
    @(negedge iCLK);
    checkOutput("first_wr_en", bus.oWR_EN, 1);
    checkOutput("first_wr_addr", bus.oWR_ADDR, 5);
    checkOutput("nonlast_stall", bus.oSTALL, 0);
    @(posedge iCLK); #1;
    wait_done(20, cyc);
    checkOutput("nonlast_done_lat", cyc, LAT + 1);
    tick();
    @(negedge iCLK);
    checkOutput("done_pulse", {bus.oDONE, bus.oBUSY}, 0);
    checkOutput("nonlast_all_written", wr_q.size(), 0);
    @(posedge iCLK); #1;

    $display("[TB] zero-length stage");
    start_stage(0, 0);
    @(negedge iCLK);
    checkOutput("zero_busy", {bus.oDONE, bus.oBUSY}, 2'b01);
    @(posedge iCLK); #1;
    @(negedge iCLK);
    checkOutput("zero_done", bus.oDONE, 1);
    @(posedge iCLK); #1;

    $display("[TB] start pulse during RUN");
    start_stage(0, 3);
    bus.iSTART = 1'b1; bus.iN_BUT = '0; bus.iST_LAST = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    for (int a = 20; a <= 22; a++) applyStimulus(A_BIT'(a), 1'b1);
    wait_done(20, cyc);
    checkOutput("ign_done_lat", cyc, LAT + 2);
    checkOutput("ign_all_written", wr_q.size(), 0);
    @(posedge iCLK); #1;

    $display("[TB] last stage back-pressure");
    ready_mode = 0;
    start_stage(1, 12);
    issued = 0;
    issue_until(12, 16, 40, issued);
    checkOutput("stall_reads", issued, FIFO_DEPTH);
    checkOutput("stall_high", bus.oSTALL, 1);
    repeat (4) tick();
    @(negedge iCLK);
    checkOutput("held_valid", bus.oOUT_VALID, 1);
    checkOutput("held_head", bus.oOUT_Y_0, yval(A_BIT'(40), 0));
    checkOutput("held_no_pop", fifo_q.size(), FIFO_DEPTH);
    @(posedge iCLK); #1;
    ready_mode = 1;
    tick(); tick();
    checkOutput("stall_falls", bus.oSTALL, 0);
    issue_until(12, 40, 40, issued);
    checkOutput("drain_reads", issued, 12);
    wait_done(60, cyc);
    checkOutput("bp_all_out", fifo_q.size(), 0);
    checkOutput("bp_err", bus.oERR, 0);
    @(posedge iCLK); #1;

    $display("[TB] last stage, ready toggling");
    ready_mode = 2;
    start_stage(1, 16);
    issued = 0;
    issue_until(16, 100, 100, issued);
    checkOutput("tog_reads", issued, 16);
    wait_done(200, cyc);
    checkOutput("tog_all_out", fifo_q.size(), 0);
    checkOutput("tog_empty_at_done", bus.oOUT_VALID, 0);
    checkOutput("tog_err", bus.oERR, 0);
    @(posedge iCLK); #1;

    $display("[TB] protocol violation");
    ready_mode = 0;
    tick();
    start_stage(1, 12);
    issued = 0;
    issue_until(8, 16, 200, issued);
    checkOutput("viol_stall", bus.oSTALL, 1);
    applyStimulus(A_BIT'(300), 1'b0);
    @(negedge iCLK);
    checkOutput("err_set", bus.oERR, 1);
    @(posedge iCLK); #1;
    applyStimulus(A_BIT'(301), 1'b0);
    repeat (6) tick();
    checkOutput("err_sticky", bus.oERR, 1);
    checkOutput("viol_held", fifo_q.size(), FIFO_DEPTH);
    ready_mode = 1;
    issued = 10;
    issue_until(12, 40, 200, issued);
    checkOutput("viol_reads", issued, 12);
    wait_done(60, cyc);
    checkOutput("viol_all_out", fifo_q.size(), 0);
    checkOutput("err_after_done", bus.oERR, 1);
    @(posedge iCLK); #1;

    $display("[TB] reset mid-stage");
    ready_mode = 0;
    start_stage(0, 4);
    applyStimulus(A_BIT'(400), 1'b1);
    applyStimulus(A_BIT'(401), 1'b1);
    checkOutput("pre_rst_busy", bus.oBUSY, 1);
    iRESET = 1'b1;
    #1;
    checkOutput("mid_rst_flags", {bus.oWR_EN, bus.oSTALL, bus.oOUT_VALID, bus.oBUSY, bus.oDONE, bus.oERR}, 0);
    checkOutput("mid_rst_wr", {bus.oWR_ADDR, bus.oWR_D_0}, 0);
    wr_q.delete();
    fifo_q.delete();
    tick(); tick();
    iRESET = 1'b0;
    repeat (8) tick();
    start_stage(0, 2);
    applyStimulus(A_BIT'(410), 1'b1);
    applyStimulus(A_BIT'(411), 1'b1);
    wait_done(20, cyc);
    checkOutput("post_rst_done_lat", cyc, LAT + 2);
    checkOutput("post_rst_written", wr_q.size(), 0);
    checkOutput("post_rst_err", bus.oERR, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
